// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 keyboard and joystick to per-player arcade buttons
// Optional autofire is built only when INPUT_MAPPER_AUTOFIRE_EN is defined.
module arcade_input_mapper #(
    parameter int PLAYERS   = 2,
    parameter int MERGE_JOY = 1,
    parameter int COIN_MIN  = 16,
    parameter int AF_HALF   = 4096
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [10:0]           ps2_key,
    input  logic [16*PLAYERS-1:0] joy,
    input  logic [PLAYERS-1:0]    autofire,
    output logic [8*PLAYERS-1:0]  btn
);
    localparam logic       P2_EN     = (PLAYERS > 1);
    localparam logic [7:0] COIN_LOAD = 8'(COIN_MIN);

    logic        r_prev_tog;
    logic [17:0] r_keys;
    logic        w_evt;
    logic        w_hit;
    logic [4:0]  w_idx;
    logic [15:0] w_joy_any;
    logic        w_unused;

    assign w_evt    = ps2_key[10] ^ r_prev_tog;
    assign w_unused = ^{joy, autofire, r_keys};

    // Nine key slots per player: right, left, down, up, fire, bomb, start A, start B, coin
    always_comb begin
        w_hit = 1'b1;
        w_idx = 5'd0;
        case (ps2_key[7:0])
            8'h74: w_idx = 5'd0;
            8'h6B: w_idx = 5'd1;
            8'h72: w_idx = 5'd2;
            8'h75: w_idx = 5'd3;
            8'h14: w_idx = 5'd5;
            8'h29: begin w_idx = 5'd4;  w_hit = ~ps2_key[8]; end
            8'h05: begin w_idx = 5'd6;  w_hit = ~ps2_key[8]; end
            8'h16: begin w_idx = 5'd7;  w_hit = ~ps2_key[8]; end
            8'h2E: begin w_idx = 5'd8;  w_hit = ~ps2_key[8]; end
            8'h34: begin w_idx = 5'd9;  w_hit = ~ps2_key[8] & P2_EN; end
            8'h23: begin w_idx = 5'd10; w_hit = ~ps2_key[8] & P2_EN; end
            8'h2B: begin w_idx = 5'd11; w_hit = ~ps2_key[8] & P2_EN; end
            8'h2D: begin w_idx = 5'd12; w_hit = ~ps2_key[8] & P2_EN; end
            8'h1C: begin w_idx = 5'd13; w_hit = ~ps2_key[8] & P2_EN; end
            8'h1B: begin w_idx = 5'd14; w_hit = ~ps2_key[8] & P2_EN; end
            8'h06: begin w_idx = 5'd15; w_hit = ~ps2_key[8] & P2_EN; end
            8'h1E: begin w_idx = 5'd16; w_hit = ~ps2_key[8] & P2_EN; end
            8'h36: begin w_idx = 5'd17; w_hit = ~ps2_key[8] & P2_EN; end
            default: w_hit = 1'b0;
        endcase
    end

    always_comb begin
        w_joy_any = '0;
        for (int i = 0; i < PLAYERS; i++) begin
            w_joy_any = w_joy_any | joy[16*i +: 16];
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_prev_tog <= 1'b0;
            r_keys     <= '0;
        end else begin
            r_prev_tog <= ps2_key[10];
            if (w_evt && w_hit) begin
                r_keys[w_idx] <= ps2_key[9];
            end
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [8:0] w_k;
        logic [7:0] w_jb;
        logic [7:0] w_raw;
        logic       w_fire;
        logic [7:0] w_coin_next;
        logic [7:0] r_coin_cnt;
        logic       r_coin_prev;
        logic [7:0] r_btn;

        assign w_k = r_keys[9*p +: 9];

        if (MERGE_JOY != 0) begin : g_merge
            assign w_jb = {(p == 0) ? w_joy_any[8] : 1'b0,
                           (p == 0) ? w_joy_any[6] : w_joy_any[7],
                           w_joy_any[5:0]};
        end else begin : g_split
            assign w_jb = {joy[16*p+8], joy[16*p+6], joy[16*p +: 6]};
        end

        assign w_raw = {w_k[8], w_k[6] | w_k[7], w_k[5:0]} | w_jb;

        // Output uses the post-update count so the stretch lasts exactly COIN_MIN cycles
        assign w_coin_next = (w_raw[7] & ~r_coin_prev) ? COIN_LOAD :
                             (r_coin_cnt != 8'd0) ? r_coin_cnt - 8'd1 : 8'd0;

`ifdef INPUT_MAPPER_AUTOFIRE_EN
        localparam logic [15:0] AF_LIM = 16'(AF_HALF);
        logic        w_af_on;
        logic [15:0] r_af_cnt;
        logic [15:0] w_af_cnt_next;
        logic        r_af_phase;
        logic        w_af_phase_next;

        assign w_af_on = autofire[p] & w_raw[4];

        // A zero count marks a fresh press: the first half-period is always high
        always_comb begin
            w_af_cnt_next   = 16'd0;
            w_af_phase_next = 1'b0;
            if (w_af_on) begin
                if (r_af_cnt == 16'd0) begin
                    w_af_cnt_next   = 16'd1;
                    w_af_phase_next = 1'b1;
                end else if (r_af_cnt == AF_LIM) begin
                    w_af_cnt_next   = 16'd1;
                    w_af_phase_next = ~r_af_phase;
                end else begin
                    w_af_cnt_next   = r_af_cnt + 16'd1;
                    w_af_phase_next = r_af_phase;
                end
            end
        end

        assign w_fire = w_af_on ? w_af_phase_next : w_raw[4];

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                r_af_cnt   <= 16'd0;
                r_af_phase <= 1'b0;
            end else begin
                r_af_cnt   <= w_af_cnt_next;
                r_af_phase <= w_af_phase_next;
            end
        end
`else
        assign w_fire = w_raw[4];
`endif

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                r_coin_cnt  <= 8'd0;
                r_coin_prev <= 1'b0;
                r_btn       <= 8'd0;
            end else begin
                r_coin_cnt  <= w_coin_next;
                r_coin_prev <= w_raw[7];
                r_btn       <= {w_raw[7] | (w_coin_next != 8'd0), w_raw[6:5], w_fire, w_raw[3:0]};
            end
        end

        assign btn[8*p +: 8] = r_btn;
    end
endmodule
